// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter
// Round-robin arbiter for byte writes to a shared HD44780-class LCD. It also
// generates the bus timing for each byte it grants.
// Each requester presents req with a stable req_rs/req_data until it is acked.
// The granted byte is latched, then driven with setup, an enable pulse, hold,
// and an execution wait. lock[i] keeps the grant with owner i between bytes.
//
// Ports
//   clk       system clock
//   reset     synchronous reset, active low
//   req       per-client write request
//   req_rs    per-client RS bit
//   req_data  per-client data byte, client i at [8i+7:8i]
//   lock      per-client request to keep the grant between bytes
//   ack       per-client pulse, high in the IDLE cycle the byte is accepted
//   grant     one-hot current/last owner, zero after reset
//   busy      high in every state except IDLE
//   rs, rw, enable, data   LCD pins (rw is always 0)
//
// state      | meaning
// -----------+------------------------------------------------------------
// INIT_WAIT  | power-on delay after reset
// IDLE       | arbitrate; accept a byte in the same cycle
// SETUP      | rs/data driven, enable low
// PULSE      | enable high
// HOLD       | enable low, rs/data still held
// EXEC       | wait for the LCD to execute (long for clear/home commands)
module lcd_write_arbiter #(
    parameter int NUM_REQ          = 2,
    parameter int POWERON_CYCLES   = 750000,
    parameter int SETUP_CYCLES     = 4,
    parameter int PULSE_CYCLES     = 25,
    parameter int HOLD_CYCLES      = 4,
    parameter int EXEC_CYCLES      = 2500,
    parameter int LONG_EXEC_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_rs,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   lock,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 rs,
    output logic                 rw,
    output logic                 enable,
    output logic [7:0]           data
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(max2(POWERON_CYCLES, SETUP_CYCLES),
                                       max2(PULSE_CYCLES, HOLD_CYCLES)),
                                  max2(EXEC_CYCLES, LONG_EXEC_CYCLES));
    localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // The counter is loaded with length-1 and the state is left when it reaches 0.
    localparam logic [CNT_W-1:0] POWERON_LD = CNT_W'(POWERON_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LD   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] EXEC_LD    = CNT_W'(EXEC_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LD    = CNT_W'(LONG_EXEC_CYCLES - 1);

    typedef enum logic [2:0] {
        S_INIT_WAIT = 3'd0,
        S_IDLE      = 3'd1,
        S_SETUP     = 3'd2,
        S_PULSE     = 3'd3,
        S_HOLD      = 3'd4,
        S_EXEC      = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rs_q, rs_d;
    logic [7:0]         data_q, data_d;
    logic               enable_q, enable_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic               owner_vld_q, owner_vld_d;

    logic [NUM_REQ-1:0] eligible;
    logic               owner_locked;
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W:0]     cand;
    logic [PTR_W:0]     ptr_inc;
    logic               do_grant;
    logic               win_rs;
    logic [7:0]         win_data;
    logic               long_cmd;

    // Arbitration. A live lock masks every requester except the owner.
    always_comb begin
        owner_locked = owner_vld_q && lock[owner_q];
        eligible     = req;
        if (owner_locked) begin
            eligible = req & (NUM_REQ'(1) << owner_q);
        end
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!win_found && eligible[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
        ptr_inc = {1'b0, win_idx} + (PTR_W+1)'(1);
        if (ptr_inc >= (PTR_W+1)'(NUM_REQ)) begin
            ptr_inc = '0;
        end
        win_rs   = 1'b0;
        win_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == win_idx) begin
                win_rs   = req_rs[i];
                win_data = req_data[8*i +: 8];
            end
        end
        do_grant = (state_q == S_IDLE) && win_found;
        long_cmd = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02) || (data_q == 8'h03));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_INIT_WAIT;
            cnt_q       <= POWERON_LD;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            enable_q    <= 1'b0;
            grant_q     <= '0;
            ptr_q       <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            enable_q    <= enable_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_INIT_WAIT: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_IDLE: begin
                if (do_grant) begin
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_EXEC;
                    cnt_d   = long_cmd ? LONG_LD : EXEC_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: begin
                state_d = S_INIT_WAIT;
                cnt_d   = POWERON_LD;
            end
        endcase
    end

    // Outputs and datapath
    always_comb begin
        ack         = do_grant ? (NUM_REQ'(1) << win_idx) : '0;
        rs_d        = rs_q;
        data_d      = data_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        if (state_q == S_IDLE) begin
            // A dropped lock releases the owner even if nobody is granted now.
            if (!owner_locked) owner_vld_d = 1'b0;
            if (do_grant) begin
                rs_d        = win_rs;
                data_d      = win_data;
                grant_d     = NUM_REQ'(1) << win_idx;
                ptr_d       = ptr_inc[PTR_W-1:0];
                owner_d     = win_idx;
                owner_vld_d = 1'b1;
            end
        end
        // Registered from the next state, so enable cannot glitch.
        enable_d = (state_d == S_PULSE);
        busy     = (state_q != S_IDLE);
    end

    assign grant  = grant_q;
    assign rs     = rs_q;
    assign rw     = 1'b0;
    assign enable = enable_q;
    assign data   = data_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
module tb_lcd_write_arbiter;

    localparam int N   = 2;
    localparam int PWR = 10;
    localparam int S   = 2;
    localparam int P   = 3;
    localparam int H   = 2;
    localparam int E   = 5;
    localparam int L   = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  req_rs = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  lock = '0;
    logic [1:0]  ack;
    logic [1:0]  grant;
    logic        busy;
    logic        rs;
    logic        rw;
    logic        enable;
    logic [7:0]  data;

    lcd_write_arbiter #(
        .NUM_REQ(N), .POWERON_CYCLES(PWR), .SETUP_CYCLES(S), .PULSE_CYCLES(P),
        .HOLD_CYCLES(H), .EXEC_CYCLES(E), .LONG_EXEC_CYCLES(L)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_rs(req_rs), .req_data(req_data),
        .lock(lock), .ack(ack), .grant(grant), .busy(busy), .rs(rs), .rw(rw),
        .enable(enable), .data(data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rs;
        logic [7:0] d;
    } byte_t;

    byte_t q0[$];
    byte_t q1[$];

    int checks = 0;
    int errors = 0;

    // Reference model: transaction-level bookkeeping in cycle numbers
    int         c;
    int         free_at;
    int         en_lo, en_hi;
    int         ptr;
    int         own;
    bit         own_v;
    logic       exp_rs;
    logic [7:0] exp_data;
    logic [1:0] exp_grant;
    logic [1:0] lock_v = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s c=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    task automatic push(input int cl, input logic r, input logic [7:0] d);
        byte_t b;
        b.rs = r;
        b.d  = d;
        if (cl == 0) q0.push_back(b);
        else         q1.push_back(b);
    endtask

    function automatic int dut_win();
        if (ack == 2'b01) return 0;
        if (ack == 2'b10) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        c         = 0;
        free_at   = PWR;
        en_lo     = 1;
        en_hi     = 0;
        ptr       = 0;
        own       = 0;
        own_v     = 0;
        exp_rs    = 1'b0;
        exp_data  = 8'h00;
        exp_grant = 2'b00;
    endtask

    // One clock cycle: drive clients, then check every output against the model.
    task automatic cycle();
        logic [1:0] elig;
        logic [1:0] exp_ack;
        int         w;
        int         len;
        byte_t      b;
        @(negedge clk);
        reset = 1'b1;
        if (q0.size() > 0) begin
            req[0] = 1'b1; req_rs[0] = q0[0].rs; req_data[7:0] = q0[0].d;
        end else begin
            req[0] = 1'b0;
        end
        if (q1.size() > 0) begin
            req[1] = 1'b1; req_rs[1] = q1[0].rs; req_data[15:8] = q1[0].d;
        end else begin
            req[1] = 1'b0;
        end
        lock = lock_v;
        #1;
        exp_ack = 2'b00;
        w = -1;
        if (c >= free_at) begin
            elig = req;
            if (own_v && (((lock >> own) & 2'b01) != 2'b00)) elig = req & (2'b01 << own);
            else own_v = 0;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && (((elig >> ((ptr + k) % N)) & 2'b01) != 2'b00)) w = (ptr + k) % N;
            end
            if (w >= 0) exp_ack = 2'b01 << w;
        end
        chk("ack", ack, exp_ack);
        chk("busy", busy, (c < free_at));
        chk("enable", enable, (c >= en_lo && c <= en_hi));
        chk("rs", rs, exp_rs);
        chk("data", data, exp_data);
        chk("grant", grant, exp_grant);
        chk("rw", rw, 1'b0);
        if (w >= 0) begin
            b = (w == 0) ? q0.pop_front() : q1.pop_front();
            exp_rs    = b.rs;
            exp_data  = b.d;
            exp_grant = 2'b01 << w;
            len       = (!b.rs && b.d >= 8'h01 && b.d <= 8'h03) ? L : E;
            free_at   = c + S + P + H + len + 1;
            en_lo     = c + S + 1;
            en_hi     = c + S + P;
            ptr       = (w + 1) % N;
            own       = w;
            own_v     = 1;
        end
        c++;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_enable", enable, 1'b0);
        chk("rst_data", data, 8'h00);
        chk("rst_rs", rs, 1'b0);
        chk("rst_busy", busy, 1'b1);
        chk("rst_ack", ack, 2'b00);
        chk("rst_grant", grant, 2'b00);
        repeat (n - 1) @(negedge clk);
        model_reset();
    endtask

    initial begin
        int first, n_en, nt, nw, n1, n0, dw, drop_c, got;
        int t[4];
        int wins[12];
        bit added;
        bit seen;

        model_reset();
        do_reset(3);

        // Power-up: single byte from client 0 waits out the power-on delay
        push(0, 1'b1, 8'h41);
        first = -1;
        n_en  = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (dut_win() == 0 && first < 0) first = c - 1;
            if (enable) n_en++;
        end
        chk("pwr_first_ack", first, PWR);
        chk("pwr_enable_width", n_en, P);

        // Long command timing
        push(0, 1'b0, 8'h01);
        push(0, 1'b1, 8'h35);
        push(0, 1'b0, 8'h0C);
        push(0, 1'b1, 8'h35);
        t = '{default: 0};
        nt = 0;
        for (int i = 0; i < 120 && nt < 4; i++) begin
            cycle();
            if (dut_win() == 0) begin
                t[nt] = c - 1;
                nt++;
            end
        end
        chk("long_count", nt, 4);
        chk("long_gap", t[1] - t[0], S + P + H + L + 1);
        chk("short_gap_a", t[2] - t[1], S + P + H + E + 1);
        chk("short_gap_b", t[3] - t[2], S + P + H + E + 1);
        repeat (20) cycle();

        // Round robin, both clients busy, no locks
        for (int i = 0; i < 6; i++) begin
            push(0, 1'b1, 8'($urandom_range(32, 126)));
            push(1, 1'b1, 8'($urandom_range(32, 126)));
        end
        nw = 0;
        for (int i = 0; i < 200 && nw < 12; i++) begin
            cycle();
            dw = dut_win();
            if (dw >= 0) begin
                wins[nw] = dw;
                nw++;
            end
        end
        chk("rr_count", nw, 12);
        for (int k = 1; k < 12; k++) chk("rr_alternate", wins[k], 1 - wins[k-1]);
        repeat (20) cycle();

        // Lock burst from client 1 while client 0 waits
        lock_v = 2'b10;
        push(1, 1'b0, 8'hC4);
        push(1, 1'b1, 8'h45);
        push(1, 1'b1, 8'h4E);
        nw = 0;
        n1 = 0;
        added = 0;
        for (int i = 0; i < 200 && nw < 4; i++) begin
            cycle();
            dw = dut_win();
            if (dw >= 0 && nw < 12) begin
                wins[nw] = dw;
                nw++;
            end
            if (dw == 1) n1++;
            if (!added && dw == 1) begin
                push(0, 1'b1, 8'h30);
                added = 1;
            end
            if (dw == 1 && n1 == 3) lock_v = 2'b00;
        end
        chk("lock_count", nw, 4);
        chk("lock_seq0", wins[0], 1);
        chk("lock_seq1", wins[1], 1);
        chk("lock_seq2", wins[2], 1);
        chk("lock_seq3", wins[3], 0);
        repeat (30) cycle();

        // Locked owner not requesting still blocks the other client
        lock_v = 2'b10;
        push(1, 1'b1, 8'h21);
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            cycle();
            if (dut_win() == 1) seen = 1;
        end
        chk("locked_owner_ack", seen, 1'b1);
        push(0, 1'b1, 8'h5A);
        push(0, 1'b1, 8'h5B);
        n0 = 0;
        repeat (60) begin
            cycle();
            if (ack[0]) n0++;
        end
        chk("locked_idle_no_ack0", n0, 0);
        lock_v = 2'b00;
        drop_c = c;
        got = -1;
        for (int i = 0; i < 40 && got < 0; i++) begin
            cycle();
            if (ack[0]) got = c - 1;
        end
        chk("unlock_ack0_cycle", got, drop_c);
        repeat (30) cycle();

        // Randomised traffic with random lock toggling
        for (int i = 0; i < 1500; i++) begin
            if (q0.size() == 0 && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3))
                    push(0, 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom));
            end
            if (q1.size() == 0 && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3))
                    push(1, 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom));
            end
            if ($urandom_range(0, 15) == 0) lock_v = 2'($urandom_range(0, 3));
            cycle();
        end

        // Reset in the middle of an enable pulse
        lock_v = 2'b00;
        repeat (60) cycle();
        push(0, 1'b1, 8'h77);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            cycle();
            if (enable) seen = 1;
        end
        chk("pulse_reached", seen, 1'b1);
        do_reset(1);
        if (q0.size() == 0) push(0, 1'b1, 8'h66);
        first = -1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (dut_win() >= 0 && first < 0) first = c - 1;
        end
        chk("post_reset_first_ack", first, PWR);
        repeat (40) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
